// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential divider: data width, iteration count,
// FSM encoding and the two's-complement helpers used by the sign-fix stage.
package div_seq_32_pkg;

    localparam int DATA_INDEX_LIMIT = 31;
    localparam int DATA_W           = DATA_INDEX_LIMIT + 1;
    localparam int DIV_ITER         = 32;
    localparam int CNT_W            = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_RUN  = 2'd1,
        DIV_ST_FIX  = 2'd2,
        DIV_ST_DONE = 2'd3
    } divState_t;

    function automatic logic [DATA_INDEX_LIMIT:0] twosNeg(input logic [DATA_INDEX_LIMIT:0] x);
        return (x ^ {DATA_W{1'b1}}) + DATA_W'(1);
    endfunction

    // Magnitude of a two's-complement value; -2^31 maps to 32'h80000000 read as unsigned.
    function automatic logic [DATA_INDEX_LIMIT:0] absVal(input logic [DATA_INDEX_LIMIT:0] x);
        return x[DATA_INDEX_LIMIT] ? twosNeg(x) : x;
    endfunction

endpackage

// File: rtl/div_seq_32_rc_add_sub.sv
// 32-bit ripple-carry adder/subtractor: SnA=1 computes A-B as A+~B+1, and CO=1
// then means A >= B (unsigned).
module div_seq_32_rc_add_sub
    import div_seq_32_pkg::*;
(
    input  logic [DATA_INDEX_LIMIT:0] A,
    input  logic [DATA_INDEX_LIMIT:0] B,
    input  logic                      SnA,
    output logic [DATA_INDEX_LIMIT:0] Y,
    output logic                      CO
);

    logic [DATA_INDEX_LIMIT:0] bEff;
    logic [DATA_W:0]           carry;

    always_comb begin
        bEff     = B ^ {DATA_W{SnA}};
        carry    = '0;
        Y        = '0;
        carry[0] = SnA;
        for (int i = 0; i < DATA_W; i++) begin
            Y[i]       = A[i] ^ bEff[i] ^ carry[i];
            carry[i+1] = (A[i] & bEff[i]) | (carry[i] & (A[i] ^ bEff[i]));
        end
        CO = carry[DATA_W];
    end

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle restoring divider, one quotient bit per clock through one ripple
// add/sub stage. Define DIV_SIGNED_EN for two's-complement operands.
module div_seq_32
    import div_seq_32_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [DATA_INDEX_LIMIT:0] DVND,
    input  logic [DATA_INDEX_LIMIT:0] DVSR,
    output logic [DATA_INDEX_LIMIT:0] QUO,
    output logic [DATA_INDEX_LIMIT:0] REM,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      DIV_BY_ZERO,
    output divState_t                 stateDbg
);

    // Handshake: START is a request taken only in IDLE or DONE; once taken the
    // operation runs to completion, and DONE is a one-cycle pulse marking
    // QUO/REM/DIV_BY_ZERO valid. There is no back-pressure on the result.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

    divState_t                 state;
    logic [DATA_INDEX_LIMIT:0] partRem;
    logic [DATA_INDEX_LIMIT:0] qReg;
    logic [DATA_INDEX_LIMIT:0] divisorMag;
    logic [CNT_W-1:0]          cnt;

    logic [DATA_W:0]           rShift;
    logic [DATA_INDEX_LIMIT:0] diff;
    logic                      carryOut;
    logic                      takeSub;
    logic [DATA_INDEX_LIMIT:0] dvndMag;
    logic [DATA_INDEX_LIMIT:0] dvsrMag;
    logic [DATA_INDEX_LIMIT:0] quoFix;
    logic [DATA_INDEX_LIMIT:0] remFix;

`ifdef DIV_SIGNED_EN
    logic quoNeg;
    logic remNeg;
`endif

    // partRem never needs a 33rd flop: a set shifted top bit always forces a subtract.
    assign rShift = {partRem, qReg[DATA_INDEX_LIMIT]};

    div_seq_32_rc_add_sub rcAddSub (
        .A   (rShift[DATA_INDEX_LIMIT:0]),
        .B   (divisorMag),
        .SnA (1'b1),
        .Y   (diff),
        .CO  (carryOut)
    );

    assign takeSub  = rShift[DATA_W] | carryOut;
    assign stateDbg = state;

`ifdef DIV_SIGNED_EN
    assign dvndMag = absVal(DVND);
    assign dvsrMag = absVal(DVSR);
    assign quoFix  = quoNeg ? twosNeg(qReg) : qReg;
    assign remFix  = remNeg ? twosNeg(partRem) : partRem;
`else
    assign dvndMag = DVND;
    assign dvsrMag = DVSR;
    assign quoFix  = qReg;
    assign remFix  = partRem;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= DIV_ST_IDLE;
            QUO         <= '0;
            REM         <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
            partRem     <= '0;
            qReg        <= '0;
            divisorMag  <= '0;
            cnt         <= '0;
`ifdef DIV_SIGNED_EN
            quoNeg      <= 1'b0;
            remNeg      <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                DIV_ST_IDLE, DIV_ST_DONE: begin
                    if (START) begin
                        DIV_BY_ZERO <= 1'b0;
                        partRem     <= '0;
                        qReg        <= dvndMag;
                        divisorMag  <= dvsrMag;
                        cnt         <= '0;
`ifdef DIV_SIGNED_EN
                        quoNeg      <= DVND[DATA_INDEX_LIMIT] ^ DVSR[DATA_INDEX_LIMIT];
                        remNeg      <= DVND[DATA_INDEX_LIMIT];
`endif
                        if (DVSR == '0) begin
                            QUO         <= '1;
                            REM         <= DVND;
                            DIV_BY_ZERO <= 1'b1;
                            DONE        <= 1'b1;
                            state       <= DIV_ST_DONE;
                        end else begin
                            BUSY  <= 1'b1;
                            state <= DIV_ST_RUN;
                        end
                    end else if (state == DIV_ST_DONE) begin
                        state <= DIV_ST_IDLE;
                    end
                end
                DIV_ST_RUN: begin
                    partRem <= takeSub ? diff : rShift[DATA_INDEX_LIMIT:0];
                    qReg    <= {qReg[DATA_INDEX_LIMIT-1:0], takeSub};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state <= DIV_ST_FIX;
                    end
                end
                DIV_ST_FIX: begin
                    QUO   <= quoFix;
                    REM   <= remFix;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= DIV_ST_DONE;
                end
                default: state <= DIV_ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_seq_32.md
# div_seq_32

Multi-cycle 32-bit restoring divider for the DaVinci ALU's DIV operation. It sits directly upstream of the ripple-carry add/sub stage. Each cycle it feeds one `RC_ADD_SUB_32` instance a shifted partial remainder and the divisor with subtract selected. It then uses the returned difference and carry-out to build quotient and remainder bits, one per clock.

## Interface
Parameters:
- none; width fixed by `` `DATA_INDEX_LIMIT `` (31) from `prj_definition.v`

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-low reset
- START  in  1  request; sampled only in IDLE or DONE state
- DVND  in  32  dividend, captured on accepted START
- DVSR  in  32  divisor, captured on accepted START
- QUO  out  32  quotient, registered
- REM  out  32  remainder, registered
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle pulse; QUO/REM valid from this cycle
- DIV_BY_ZERO  out  1  registered flag, valid with DONE, held until next accepted START

## Operation
- Reset (RST=0 at a rising edge): state=IDLE; QUO=0, REM=0, BUSY=0, DONE=0, DIV_BY_ZERO=0. This holds regardless of current state, including mid-RUN.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE with START=1:
  - Capture operands.
  - Clear DIV_BY_ZERO.
  - R (33-bit partial remainder) = 0; Qreg = dividend magnitude; count = 0.
  - If DVSR==0, go to DONE; otherwise go to RUN.
- IDLE/DONE with START=0: DONE→IDLE; IDLE stays.
- RUN, one iteration per cycle:
  - R' = {R[31:0], Qreg[31]}.
  - Adder inputs: A=R'[31:0], B=divisor magnitude, SnA=1.
  - If R'[32] | CO, then R = {0, Y} and Qreg = {Qreg[30:0], 1}.
  - Otherwise R = R' and Qreg = {Qreg[30:0], 0}.
  - count increments; after the 32nd iteration go to FIX.
- FIX: apply sign correction (see Configuration), load QUO/REM, go to DONE.
- DONE: DONE=1 for exactly one cycle, BUSY=0. QUO/REM/DIV_BY_ZERO hold until the next accepted START.
- Divide by zero: QUO=32'hFFFFFFFF, REM=DVND, DIV_BY_ZERO=1.
- START while BUSY: ignored; running operation unaffected.
- DVND/DVSR changes after capture: no effect.

## Timing
- START accepted at edge k. BUSY=1 over cycles k+1..k+33 (RUN k+1..k+32, FIX k+33). DONE=1 at cycle k+34.
- Total latency 34 cycles, fixed, independent of operand values and of the signed macro.
- Divide by zero: DONE at cycle k+1; BUSY never asserts.
- Back-to-back: START in the DONE cycle is accepted; the next operation's DONE is at +34.
- Adder path is combinational inside one cycle; no added pipeline stages.

## Configuration
- `DIV_SIGNED_EN` defined: operands are two's complement.
  - Magnitudes are used in RUN.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative.
  - -2^31 / -1 yields QUO=32'h80000000, REM=0 (wrap, no flag).
  - Divide by zero: QUO=32'hFFFFFFFF, REM=DVND.
- Undefined: unsigned only; FIX copies Qreg/R[31:0] unchanged. FIX is still one cycle, so latency stays 34.

## Structure
- Shared definitions file `prj_definition.v` holds:
  - state encodings: `DIV_ST_IDLE`, `DIV_ST_RUN`, `DIV_ST_FIX`, `DIV_ST_DONE`
  - iteration count constant `DIV_ITER` = 32
  - existing `` `DATA_INDEX_LIMIT ``
- Sub-module: one `RC_ADD_SUB_32` instance for trial subtraction. Sign negation in FIX uses XOR+increment logic local to the block.

## Test plan
- Unsigned 100 / 7, START at cycle 0 -> DONE at cycle 34, QUO=14, REM=2, DIV_BY_ZERO=0.
- 32'hFFFFFFFF / 1 -> QUO=32'hFFFFFFFF, REM=0; then 5 / 32'hFFFFFFFF -> QUO=0, REM=5 (unsigned build).
- 1234 / 0 -> DONE at cycle 1, QUO=32'hFFFFFFFF, REM=1234, DIV_BY_ZERO=1, BUSY stays 0.
- Signed build: -7 / 2 -> QUO=32'hFFFFFFFD, REM=32'hFFFFFFFF. Then 32'h80000000 / -1 -> QUO=32'h80000000, REM=0.
- START pulsed at cycles 0 and 10 with different operands -> only the first result, at cycle 34. RST=0 at cycle 15 -> all outputs 0, IDLE, and no DONE pulse.
- START held high through DONE (cycle 34) with new operands 50 / 5 -> second DONE at cycle 68, QUO=10, REM=0.
